// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if
// Bundles the SPI pins and the word-level handshake of the spi_slave_if
// responder so that both can be passed around as one port.
//   SPI pins     : sck, cs_n, mosi (into the responder), miso, miso_oe (out)
//   Transmit port: tx_data, tx_valid (into the responder), tx_ready (out)
//   Receive port : rx_data, rx_valid (out of the responder)
//   Status       : tx_underrun, busy (out of the responder)
// Modports:
//   slave  - the responder side (spi_slave_if itself)
//   master - whatever drives the SPI pins and the tx port
interface spi_slave_if_if #(
  parameter int DW = 8
);
  logic          sck;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_underrun;
  logic          busy;

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sck, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if
// SPI mode-0 responder with a fixed word width. sck, cs_n and mosi are
// oversampled in the clk domain. Received words appear on rx_data with a
// one-cycle rx_valid pulse; transmit words are taken through a one-entry
// valid/ready holding buffer and fall back to DEFAULT_TX when it is empty.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - spi_slave_if_if.slave: SPI pins, tx write port, rx word port,
//          tx_underrun and busy status
// Parameters:
//   DW         - word width in bits (2..32)
//   DEFAULT_TX - word shifted out when the tx buffer is empty at a load point
// Build option:
//   SPI_SLAVE_LSB_FIRST_EN - when defined, words go out and come in LSB
//   first; otherwise MSB first. Handshakes and timing are the same.
module spi_slave_if #(
  parameter int            DW         = 8,
  parameter logic [DW-1:0] DEFAULT_TX = {DW{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  spi_slave_if_if.slave bus
);

  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t        r_state;
  state_t        w_stateNxt;

  logic          r_sckQ, r_sckS, r_sckD;
  logic          r_csQ,  r_csS,  r_csD;
  logic          r_mosiQ, r_mosiS;

  logic [DW-1:0] r_txShift;
  logic [DW-2:0] r_rxShift;
  logic [CW-1:0] r_bitCnt;
  logic          r_reload;
  logic          r_full;
  logic [DW-1:0] r_buf;
  logic [DW-1:0] r_rxData;
  logic          r_rxValid;
  logic          r_underrun;
  logic          r_miso;
  logic          r_misoOe;

  logic          w_riseDet, w_fallDet, w_selDet;
  logic          w_run, w_abort, w_selLoad, w_reloadLoad, w_load;
  logic          w_write, w_shiftTx, w_sample;
  logic          w_misoNxt, w_oeNxt;
  logic          w_txBit;
  logic [DW-1:0] w_txNext;
  logic [DW-1:0] w_rxNext;
  logic [DW-2:0] w_rxKeep;

  // Two-flop synchronisers plus one delay flop for edge detection. cs_n
  // flops reset high so a deselected bus never looks like a select edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sckQ  <= 1'b0;
      r_sckS  <= 1'b0;
      r_sckD  <= 1'b0;
      r_csQ   <= 1'b1;
      r_csS   <= 1'b1;
      r_csD   <= 1'b1;
      r_mosiQ <= 1'b0;
      r_mosiS <= 1'b0;
    end else begin
      r_sckQ  <= bus.sck;
      r_sckS  <= r_sckQ;
      r_sckD  <= r_sckS;
      r_csQ   <= bus.cs_n;
      r_csS   <= r_csQ;
      r_csD   <= r_csS;
      r_mosiQ <= bus.mosi;
      r_mosiS <= r_mosiQ;
    end
  end

  assign w_riseDet = r_sckS & ~r_sckD;
  assign w_fallDet = ~r_sckS & r_sckD;
  assign w_selDet  = ~r_csS & r_csD;

  // Bit order lives only here: which end of tx_shift drives miso and which
  // end of the receive word the new mosi bit enters.
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_txBit  = r_txShift[0];
  assign w_txNext = {1'b0, r_txShift[DW-1:1]};
  assign w_rxNext = {r_mosiS, r_rxShift};
  assign w_rxKeep = w_rxNext[DW-1:1];
`else
  assign w_txBit  = r_txShift[DW-1];
  assign w_txNext = {r_txShift[DW-2:0], 1'b0};
  assign w_rxNext = {r_rxShift, r_mosiS};
  assign w_rxKeep = w_rxNext[DW-2:0];
`endif

  // Deselect is tested before any sck edge, so an edge arriving together
  // with cs_n going high is ignored.
  assign w_run        = (r_state == S_ACTIVE) & ~r_csS;
  assign w_abort      = (r_state == S_ACTIVE) & r_csS;
  assign w_selLoad    = (r_state == S_IDLE) & w_selDet;
  assign w_reloadLoad = w_run & w_fallDet & r_reload;
  assign w_load       = w_selLoad | w_reloadLoad;
  assign w_write      = bus.tx_valid & ~r_full;
  assign w_shiftTx    = w_run & w_fallDet & ~r_reload;
  assign w_sample     = w_run & w_riseDet;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNxt;
  end

  // Next-state logic: a select edge starts a frame, deselect ends it.
  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      S_IDLE:   if (w_selDet) w_stateNxt = S_ACTIVE;
      S_ACTIVE: if (r_csS)    w_stateNxt = S_IDLE;
      default:  w_stateNxt = S_IDLE;
    endcase
  end

  // Output logic: values that the miso/miso_oe registers take next.
  always_comb begin
    w_misoNxt = 1'b0;
    w_oeNxt   = 1'b0;
    if (r_state == S_ACTIVE) begin
      w_misoNxt = w_txBit;
      w_oeNxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso   <= 1'b0;
      r_misoOe <= 1'b0;
    end else begin
      r_miso   <= w_misoNxt;
      r_misoOe <= w_oeNxt;
    end
  end

  // One-entry tx buffer. A load while empty cannot take a same-cycle
  // write, so that write simply stays in the buffer for the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else begin
      if (w_write) r_buf <= bus.tx_data;
      if (w_load)       r_full <= w_write;
      else if (w_write) r_full <= 1'b1;
    end
  end

  // Shift registers, bit counter and the reload flag that turns the fall
  // after a completed word into the load point of the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txShift  <= '0;
      r_rxShift  <= '0;
      r_bitCnt   <= '0;
      r_reload   <= 1'b0;
      r_rxData   <= '0;
      r_rxValid  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rxValid  <= 1'b0;
      r_underrun <= 1'b0;

      if (w_load) begin
        r_txShift  <= r_full ? r_buf : DEFAULT_TX;
        r_underrun <= ~r_full;
      end else if (w_shiftTx) begin
        r_txShift <= w_txNext;
      end

      if (w_selLoad || w_abort) begin
        r_bitCnt <= '0;
        r_reload <= 1'b0;
      end else if (w_sample) begin
        r_rxShift <= w_rxKeep;
        if (r_bitCnt == LAST) begin
          r_bitCnt  <= '0;
          r_reload  <= 1'b1;
          r_rxData  <= w_rxNext;
          r_rxValid <= 1'b1;
        end else begin
          r_bitCnt <= r_bitCnt + CW'(1);
        end
      end else if (w_reloadLoad) begin
        r_reload <= 1'b0;
      end
    end
  end

  assign bus.miso        = r_miso;
  assign bus.miso_oe     = r_misoOe;
  assign bus.tx_ready    = ~r_full;
  assign bus.rx_data     = r_rxData;
  assign bus.rx_valid    = r_rxValid;
  assign bus.tx_underrun = r_underrun;
  assign bus.busy        = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if
// Drives spi_slave_if as a mode-0 SPI master with sck half-periods of six
// clk cycles, writes transmit words through the tx port and compares the
// responder against a frame-level model: a queue for the tx buffer, a queue
// of words the responder must report, and an underrun counter.
// Honours SPI_SLAVE_LSB_FIRST_EN for the bit order on the wire.
module tb_spi_slave_if;

  localparam int         DW  = 8;
  localparam logic [7:0] DEF = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_slave_if_if #(.DW(DW)) bus ();

  spi_slave_if #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         nChecks = 0;
  int         nFail   = 0;
  logic [7:0] txq[$];
  logic [7:0] expRx[$];
  int         expUnderrun = 0;
  int         seenUnderrun = 0;
  int         rxCount = 0;
  logic [7:0] lastRx = 8'h00;
  logic       prevRxValid = 1'b0;

  logic [7:0] frameTx[4];
  logic [7:0] frameRx[4];
  bit         frameWrite[4];
  int         nWords;
  logic [7:0] seqs[4];

  // Bit i (0 = first on the wire) of a word, by the configured bit order.
  function automatic logic bitOf(input logic [7:0] w, input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_miso",      bus.miso,        0);
    checkOutput("rst_miso_oe",   bus.miso_oe,     0);
    checkOutput("rst_rx_data",   bus.rx_data,     0);
    checkOutput("rst_rx_valid",  bus.rx_valid,    0);
    checkOutput("rst_underrun",  bus.tx_underrun, 0);
    checkOutput("rst_busy",      bus.busy,        0);
    checkOutput("rst_tx_ready",  bus.tx_ready,    1);
  endtask

  // One-cycle write into the tx buffer; the model buffer must be empty.
  task automatic writeTx(input logic [7:0] d);
    checkOutput("tx_ready_before_write", bus.tx_ready, txq.size() == 0);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    txq.push_back(d);
  endtask

  // Compare process: every reported word must be the next expected one,
  // rx_valid must be a single-cycle pulse, and underrun pulses are counted.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        rxCount++;
        checkOutput("rx_valid_width", prevRxValid, 0);
        if (expRx.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL rx_unexpected: got word 0x%0h, expected no word", bus.rx_data);
        end else begin
          lastRx = expRx.pop_front();
          checkOutput("rx_data", bus.rx_data, lastRx);
        end
      end
      if (bus.tx_underrun) seenUnderrun++;
    end
    prevRxValid = bus.rx_valid;
  end

  // One cs_n window of nWords words. cutBits > 0 ends the frame after that
  // many sck rises (reset first when doReset). The final sck fall coincides
  // with cs_n rising so it is not a load point.
  task automatic applyStimulus(input int cutBits, input bit doReset);
    int         bitsDone;
    bit         aborted;
    logic [7:0] wordTx;
    logic [7:0] seq;
    bitsDone = 0;
    aborted  = 0;
    if (frameWrite[0] && txq.size() == 0) writeTx(frameTx[0]);
    repeat (3) @(negedge clk);
    bus.cs_n = 1'b0;
    bus.mosi = bitOf(frameRx[0], 0);
    repeat (8) @(negedge clk);
    for (int w = 0; w < nWords && !aborted; w++) begin
      if (txq.size() > 0) wordTx = txq.pop_front();
      else begin
        wordTx = DEF;
        expUnderrun++;
      end
      seq = 8'h00;
      for (int b = 0; b < DW && !aborted; b++) begin
        seq[7-b] = bus.miso;
        checkOutput("miso_bit", bus.miso, bitOf(wordTx, b));
        checkOutput("miso_oe", bus.miso_oe, 1);
        bus.sck = 1'b1;
        bitsDone++;
        if (b == DW-1) expRx.push_back(frameRx[w]);
        repeat (6) @(negedge clk);
        if (bitsDone == cutBits) begin
          aborted = 1;
          if (doReset) begin
            checkOutput("tx_ready_pre_reset", bus.tx_ready, txq.size() == 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkResetState();
            txq.delete();
            lastRx = 8'h00;
          end
          bus.cs_n = 1'b1;
          bus.sck  = 1'b0;
        end else if (w == nWords-1 && b == DW-1) begin
          bus.cs_n = 1'b1;
          bus.sck  = 1'b0;
        end else begin
          bus.sck  = 1'b0;
          bus.mosi = (b == DW-1) ? bitOf(frameRx[w+1], 0) : bitOf(frameRx[w], b+1);
          if (b == 1 && w+1 < nWords && frameWrite[w+1] && txq.size() == 0) begin
            writeTx(frameTx[w+1]);
            repeat (5) @(negedge clk);
          end else begin
            repeat (6) @(negedge clk);
          end
        end
      end
      seqs[w] = seq;
    end
    repeat (10) @(negedge clk);
    checkOutput("rx_all_received", expRx.size(), 0);
    expRx.delete();
    checkOutput("underrun_count", seenUnderrun, expUnderrun);
    checkOutput("busy_idle", bus.busy, 0);
    checkOutput("miso_oe_idle", bus.miso_oe, 0);
    checkOutput("miso_idle", bus.miso, 0);
    checkOutput("tx_ready_end", bus.tx_ready, txq.size() == 0);
    checkOutput("rx_data_held", bus.rx_data, lastRx);
  endtask

  task automatic setFrame(input int n, input logic [7:0] t0, input logic [7:0] r0, input bit w0,
                          input logic [7:0] t1, input logic [7:0] r1, input bit w1);
    nWords        = n;
    frameTx[0]    = t0;
    frameRx[0]    = r0;
    frameWrite[0] = w0;
    frameTx[1]    = t1;
    frameRx[1]    = r1;
    frameWrite[1] = w1;
    frameTx[2]    = 8'h00;
    frameRx[2]    = 8'h00;
    frameWrite[2] = 0;
    frameTx[3]    = 8'h00;
    frameRx[3]    = 8'h00;
    frameWrite[3] = 0;
  endtask

  initial begin
    int u0;
    int c0;
    bus.sck      = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    checkResetState();

    // Single word: tx 0xA5 written before select, master sends 0x3C.
    setFrame(1, 8'hA5, 8'h3C, 1, 8'h00, 8'h00, 0);
    applyStimulus(0, 0);
`ifndef SPI_SLAVE_LSB_FIRST_EN
    checkOutput("t1_miso_word", seqs[0], 8'hA5);
`endif
    checkOutput("t1_rx_data", bus.rx_data, 8'h3C);
    checkOutput("t1_tx_ready", bus.tx_ready, 1);

    // Two back-to-back words; second tx word written while the first shifts.
    c0 = rxCount;
    setFrame(2, 8'h12, 8'hF0, 1, 8'h34, 8'h0F, 1);
    applyStimulus(0, 0);
`ifndef SPI_SLAVE_LSB_FIRST_EN
    checkOutput("t2_miso_word0", seqs[0], 8'h12);
    checkOutput("t2_miso_word1", seqs[1], 8'h34);
`endif
    checkOutput("t2_rx_pulses", rxCount - c0, 2);
    checkOutput("t2_rx_data", bus.rx_data, 8'h0F);

    // Empty buffer at select: DEFAULT_TX goes out, one underrun pulse.
    u0 = seenUnderrun;
    setFrame(1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 0);
    checkOutput("t3_miso_word", seqs[0], 8'hFF);
    checkOutput("t3_underruns", seenUnderrun - u0, 1);
    checkOutput("t3_rx_data", bus.rx_data, 8'h00);

    // Deselect after three rises; 0x77 written mid-frame stays buffered.
    c0 = rxCount;
    setFrame(2, 8'hC3, 8'hFF, 1, 8'h77, 8'h00, 1);
    applyStimulus(3, 0);
    checkOutput("t4_no_rx", rxCount - c0, 0);
    checkOutput("t4_tx_ready_held", bus.tx_ready, 0);
    setFrame(1, 8'h00, 8'h5A, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 0);
`ifndef SPI_SLAVE_LSB_FIRST_EN
    checkOutput("t4_miso_word", seqs[0], 8'h77);
`endif
    checkOutput("t4_rx_data", bus.rx_data, 8'h5A);

    // Reset after five bits with a word pending in the buffer.
    setFrame(2, 8'h3C, 8'hAA, 1, 8'h99, 8'h55, 1);
    applyStimulus(5, 1);
    setFrame(1, 8'h96, 8'h69, 1, 8'h00, 8'h00, 0);
    applyStimulus(0, 0);
    checkOutput("t5_rx_data", bus.rx_data, 8'h69);

    // tx 0x01, master sends 0x80: wire order depends on the build.
    setFrame(1, 8'h01, 8'h80, 1, 8'h00, 8'h00, 0);
    applyStimulus(0, 0);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    checkOutput("t6_miso_word", seqs[0], 8'h80);
`else
    checkOutput("t6_miso_word", seqs[0], 8'h01);
`endif
    checkOutput("t6_rx_data", bus.rx_data, 8'h80);

    // Random frames of one to three words with random buffer writes.
    for (int f = 0; f < 14; f++) begin
      nWords = $urandom_range(1, 3);
      for (int w = 0; w < 4; w++) begin
        frameTx[w]    = 8'($urandom);
        frameRx[w]    = 8'($urandom);
        frameWrite[w] = ($urandom_range(0, 1) == 1);
      end
      applyStimulus(0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
